proc_hier: RTL and testbench
============================

# proc_hier

Top-level processor hierarchy: a single-cycle 16-bit processor with eight general registers, private instruction and data memories, and an internal cycle counter. It exposes a per-cycle trace interface (PC, instruction, register write, memory access, halt, cache statistics) that the simulation bench samples on every rising clock edge to produce the instruction trace and simulation log. It is the block instantiated directly under the bench; nothing sits above it.

## Interface
- MEM_WORDS, 1024 — words in each of instruction and data memory (power of two)
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  out  16  byte address of the instruction currently executing
- inst  out  16  instruction word at pc
- reg_write  out  1  register file written at the coming edge
- write_reg  out  3  destination register
- write_data  out  16  value written
- mem_read  out  1  load executing
- mem_write  out  1  store executing
- mem_addr  out  16  load/store byte address
- mem_data_in  out  16  store data
- mem_data_out  out  16  load data
- halt  out  1  HALT executing, or processor halted
- cycle_count  out  32  rising edges since reset release
- icache_req, icache_hit, dcache_req, dcache_hit  out  1 each  cache statistics; constant 0 (no caches)

## Operation
- Instruction fields: opcode = inst[15:11]; Rs = inst[10:8]; Rt = inst[7:5]; Rd(R-format) = inst[4:2]; funct = inst[1:0].
- 00000 HALT: halt=1; sets halted flag.
- 00001 NOP.
- 01000 ADDI: Rt ← Rs + sext(inst[4:0]).
- 10000 ST: Mem[Rs + sext(inst[4:0])] ← Rt.
- 10001 LD: Rt ← Mem[Rs + sext(inst[4:0])].
- 11000 LBI: Rs ← sext(inst[7:0]).
- 11011 ALU: Rd ← funct 00 Rs+Rt, 01 Rt−Rs, 10 Rs^Rt, 11 Rs&~Rt.
- 01100 BEQZ: if Rs==0, PC ← PC+2+sext(inst[7:0]).
- 00100 J: PC ← PC+2+sext(inst[10:0]).
- Any other opcode executes as NOP.
- Next PC otherwise PC+2. All arithmetic modulo 2^16, no flags, no traps.
- R0 is an ordinary register (not hardwired to zero). Register reads combinational; writes at rising edge.
- Memories word-organised; index = address[log2(MEM_WORDS):1]; bit 0 ignored; higher bits wrap. Reads combinational, writes at rising edge.
- Instruction and data memories are separate arrays holding identical initial images.
- Once halted: PC frozen, reg_write=mem_read=mem_write=0, halt held 1, cycle_count frozen.

## Timing
- Single cycle per instruction; trace outputs are combinational from current state and valid before each rising edge; the effect appears after that edge.
- Reset (rst_n low, asynchronous): PC=0, registers=0, halted=0, cycle_count=0; all trace outputs forced 0 while rst_n low. Memories are not reset.
- First instruction executes in the cycle after rst_n rises; reset asserted mid-program aborts the current instruction with no write.
- cycle_count increments on each rising edge with rst_n high and not halted; the edge executing HALT is counted.
- Load followed by a load/ALU use of the same register: value available next cycle (no hazards in single cycle).
- Store and load to the same address in consecutive cycles: load returns the stored value.

## Configuration
- MEM_LOADFILE_EN defined: both memories initialised at time 0 from hex file loadfile_all.img ($readmemh, word per line).
- Undefined: both memories initialised to all zeros, so the first instruction is HALT.

## Test plan
- Reset then LBI R1,5; ADDI R2,R1,−1; HALT -> reg_write trace R1=0x0005, R2=0x0004; halt high at PC 0x0004; cycle_count=3.
- LBI R3,0x10; LBI R4,0x7F; ST R4,[R3+2]; LD R5,[R3+2] -> mem_write addr 0x0012 data 0x007F; mem_read addr 0x0012 data_out 0x007F; R5=0x007F.
- ALU with R1=0x00F0, R2=0x0F0F, funct 00/01/10/11 -> 0x0FFF, 0x0E1F, 0x0FFF, 0x00F0.
- BEQZ R0 (0) offset +4 at PC 0 -> next pc 0x0006; BEQZ with nonzero Rs -> pc 0x0002; J −2 -> pc unchanged loop.
- Unknown opcode 11111 -> no reg/mem write, pc+2; after HALT, 5 more edges -> pc, cycle_count, outputs unchanged, halt=1.
- rst_n pulsed low mid-program -> outputs 0 immediately, pc=0 and cycle_count=0 after release, cache outputs always 0.

Source files
------------

// File: rtl/proc_hier.sv
// proc_hier: single-cycle 16-bit processor. It has eight general registers,
// separate instruction and data memories and a cycle counter, and it exposes
// a per-cycle execution trace.
//
// Memories: both start all zero (the first fetch is HALT).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pc, inst              byte address and word of the executing instruction
//   reg_write, write_reg, write_data   register write taking effect at the next edge
//   mem_read, mem_write   load / store executing
//   mem_addr              load/store byte address
//   mem_data_in           store data
//   mem_data_out          load data
//   halt                  HALT executing, or processor already halted
//   cycle_count           rising edges counted since reset release (frozen once halted)
//   icache_*/dcache_*     cache statistics, tied low (there are no caches)
//
// State table:
//   RUN    | fetching and executing one instruction per edge
//   HALTED | HALT has retired; pc, registers, memory and counter are frozen
module proc_hier #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_write,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic [15:0] mem_data_out,
  output logic        halt,
  output logic [31:0] cycle_count,
  output logic        icache_req,
  output logic        icache_hit,
  output logic        dcache_req,
  output logic        dcache_hit
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_ALU  = 5'b11011;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_J    = 5'b00100;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} stateT;

  stateT       state, nextState;
  logic [15:0] pcReg, nextPc;
  logic [31:0] cycleCnt;
  logic [15:0] regFile [8];

  logic [15:0] imem [MEM_WORDS] = '{default: 16'h0000};
  logic [15:0] dmem [MEM_WORDS] = '{default: 16'h0000};

  logic [15:0] instWord;
  logic [4:0]  opcode;
  logic [2:0]  rsIdx, rtIdx, rdIdx;
  logic [1:0]  funct;
  logic [15:0] rsVal, rtVal;
  logic [15:0] imm5Ext, imm8Ext, imm11Ext;
  logic [15:0] effAddr, ldData, pcPlus2;

  logic        wrEn, ldEn, stEn, haltNow;
  logic [2:0]  wrReg;
  logic [15:0] wrData;

  // Fetch and decode; byte address bit 0 is ignored and upper bits wrap.
  assign instWord = imem[pcReg[AW:1]];
  assign opcode   = instWord[15:11];
  assign rsIdx    = instWord[10:8];
  assign rtIdx    = instWord[7:5];
  assign rdIdx    = instWord[4:2];
  assign funct    = instWord[1:0];
  assign rsVal    = regFile[rsIdx];
  assign rtVal    = regFile[rtIdx];
  assign imm5Ext  = {{11{instWord[4]}}, instWord[4:0]};
  assign imm8Ext  = {{8{instWord[7]}}, instWord[7:0]};
  assign imm11Ext = {{5{instWord[10]}}, instWord[10:0]};
  assign effAddr  = rsVal + imm5Ext;
  assign ldData   = dmem[effAddr[AW:1]];
  assign pcPlus2  = pcReg + 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pcReg    <= '0;
      cycleCnt <= '0;
      for (int i = 0; i < 8; i++) regFile[i] <= '0;
    end else begin
      state <= nextState;
      pcReg <= nextPc;
      if (state == RUN) cycleCnt <= cycleCnt + 32'd1;
      if (wrEn) regFile[wrReg] <= wrData;
    end
  end

  // Memory has no reset; an edge seen while reset is held must not store.
  always_ff @(posedge clk) begin
    if (rst_n && stEn) dmem[effAddr[AW:1]] <= rtVal;
  end

  always_comb begin
    nextState = state;
    nextPc    = pcPlus2;
    wrEn      = 1'b0;
    wrReg     = rtIdx;
    wrData    = '0;
    ldEn      = 1'b0;
    stEn      = 1'b0;
    haltNow   = 1'b0;
    if (state == HALTED) begin
      nextPc  = pcReg;
      haltNow = 1'b1;
    end else begin
      unique case (opcode)
        OP_HALT: begin
          haltNow   = 1'b1;
          nextState = HALTED;
          nextPc    = pcReg;
        end
        OP_ADDI: begin
          wrEn   = 1'b1;
          wrData = effAddr;
        end
        OP_ST: stEn = 1'b1;
        OP_LD: begin
          ldEn   = 1'b1;
          wrEn   = 1'b1;
          wrData = ldData;
        end
        OP_LBI: begin
          wrEn   = 1'b1;
          wrReg  = rsIdx;
          wrData = imm8Ext;
        end
        OP_ALU: begin
          wrEn  = 1'b1;
          wrReg = rdIdx;
          unique case (funct)
            2'b00: wrData = rsVal + rtVal;
            2'b01: wrData = rtVal - rsVal;
            2'b10: wrData = rsVal ^ rtVal;
            2'b11: wrData = rsVal & ~rtVal;
          endcase
        end
        OP_BEQZ: if (rsVal == 16'h0000) nextPc = pcPlus2 + imm8Ext;
        OP_J:    nextPc = pcPlus2 + imm11Ext;
        default: ;
      endcase
    end
  end

  // The whole trace reads zero while reset is held.
  assign pc           = rst_n ? pcReg    : '0;
  assign inst         = rst_n ? instWord : '0;
  assign reg_write    = rst_n & wrEn;
  assign write_reg    = rst_n ? wrReg    : '0;
  assign write_data   = rst_n ? wrData   : '0;
  assign mem_read     = rst_n & ldEn;
  assign mem_write    = rst_n & stEn;
  assign mem_addr     = rst_n ? effAddr  : '0;
  assign mem_data_in  = rst_n ? rtVal    : '0;
  assign mem_data_out = rst_n ? ldData   : '0;
  assign halt         = rst_n & haltNow;
  assign cycle_count  = rst_n ? cycleCnt : '0;

  assign icache_req = 1'b0;
  assign icache_hit = 1'b0;
  assign dcache_req = 1'b0;
  assign dcache_hit = 1'b0;

endmodule

// File: tb/tb_proc_hier.sv
module tb_proc_hier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data_in, mem_data_out;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;

  always #5 clk = ~clk;

  proc_hier #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
    .cycle_count(cycle_count), .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit)
  );

  int errors = 0;
  int checks = 0;

  // Reference machine state (architectural view only).
  logic [15:0] mImem [1024];
  logic [15:0] mDmem [1024];
  logic [15:0] mRegs [8];
  logic [15:0] mPc;
  logic        mHalted;
  logic [31:0] mCycles;

  // Register/memory picture rebuilt from the DUT trace.
  logic [15:0] sRegs [8];
  logic [15:0] lastStAddr, lastStData, lastLdData;

  logic [15:0] progBuf [64];

  typedef struct {
    logic [23:0][15:0] prog;
    int                nWords;
    int                edges;
    logic [15:0]       expPc;
    logic [31:0]       expCycles;
    int                nChk;
    logic [3:0][2:0]   chkReg;
    logic [3:0][15:0]  chkVal;
    logic              chkMem;
  } vecT;
  vecT vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = '0; mHalted = 1'b0; mCycles = '0;
    for (int i = 0; i < 8; i++) begin mRegs[i] = '0; sRegs[i] = '0; end
  endtask

  // Compare the live trace with the reference, then retire one instruction
  // in the reference so it matches the state after the coming edge.
  task automatic checkCycle();
    logic [15:0] ins, rs, rt, addr, sext8, eData;
    logic [4:0]  op;
    logic        eRegWr, eRd, eWr, eHalt;
    logic [2:0]  eReg;
    ins   = mImem[mPc[10:1]];
    op    = ins[15:11];
    rs    = mRegs[ins[10:8]];
    rt    = mRegs[ins[7:5]];
    addr  = rs + {{11{ins[4]}}, ins[4:0]};
    sext8 = {{8{ins[7]}}, ins[7:0]};
    eRegWr = 1'b0; eRd = 1'b0; eWr = 1'b0; eReg = '0; eData = '0;
    eHalt  = mHalted || (op == 5'b00000);
    if (!mHalted) begin
      case (op)
        5'b01000: begin eRegWr = 1'b1; eReg = ins[7:5]; eData = addr; end
        5'b10000: eWr = 1'b1;
        5'b10001: begin eRd = 1'b1; eRegWr = 1'b1; eReg = ins[7:5]; eData = mDmem[addr[10:1]]; end
        5'b11000: begin eRegWr = 1'b1; eReg = ins[10:8]; eData = sext8; end
        5'b11011: begin
          eRegWr = 1'b1; eReg = ins[4:2];
          case (ins[1:0])
            2'd0: eData = rs + rt;
            2'd1: eData = rt - rs;
            2'd2: eData = rs ^ rt;
            default: eData = rs & ~rt;
          endcase
        end
        default: ;
      endcase
    end
    chk("pc", pc, mPc);
    chk("inst", inst, ins);
    chk("reg_write", reg_write, eRegWr);
    if (eRegWr) chk("write_reg_data", {write_reg, write_data}, {eReg, eData});
    chk("mem_rw", {mem_read, mem_write}, {eRd, eWr});
    if (eRd || eWr) chk("mem_addr", mem_addr, addr);
    if (eWr) chk("mem_data_in", mem_data_in, rt);
    if (eRd) chk("mem_data_out", mem_data_out, mDmem[addr[10:1]]);
    chk("halt", halt, eHalt);
    chk("cycle_count", cycle_count, mCycles);
    chk("cache", {icache_req, icache_hit, dcache_req, dcache_hit}, 4'b0);

    if (reg_write) sRegs[write_reg] = write_data;
    if (mem_write) begin lastStAddr = mem_addr; lastStData = mem_data_in; end
    if (mem_read) lastLdData = mem_data_out;

    if (!mHalted) begin
      if (eRegWr) mRegs[eReg] = eData;
      if (eWr) mDmem[addr[10:1]] = rt;
      case (op)
        5'b00000: mHalted = 1'b1;
        5'b01100: mPc = (rs == 16'h0) ? mPc + 16'd2 + sext8 : mPc + 16'd2;
        5'b00100: mPc = mPc + 16'd2 + {{5{ins[10]}}, ins[10:0]};
        default:  mPc = mPc + 16'd2;
      endcase
      mCycles++;
    end
  endtask

  task automatic runEdges(input int n);
    for (int e = 0; e < n; e++) begin
      checkCycle();
      @(negedge clk);
    end
  endtask

  // Hold reset, install a program image, release reset on a falling edge.
  task automatic loadProg(input int nWords);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) begin dut.imem[i] = 16'h0000; mImem[i] = 16'h0000; end
    for (int i = 0; i < nWords; i++) begin dut.imem[i] = progBuf[i]; mImem[i] = progBuf[i]; end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic setVec(input int v, input int nW, input int edges, input logic [15:0] ePc,
                        input logic [31:0] eCyc, input int nChk, input logic mem);
    vecs[v].prog = '0; vecs[v].nWords = nW; vecs[v].edges = edges; vecs[v].expPc = ePc;
    vecs[v].expCycles = eCyc; vecs[v].nChk = nChk; vecs[v].chkMem = mem;
    vecs[v].chkReg = '0; vecs[v].chkVal = '0;
  endtask

  function automatic logic [15:0] randInst();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0: w[15:11] = 5'b11000;
      1: w[15:11] = 5'b01000;
      2: w[15:11] = 5'b10000;
      3: w[15:11] = 5'b10001;
      4, 5: w[15:11] = 5'b11011;
      6: w = {5'b01100, w[10:8], 8'($urandom_range(0, 7) * 2)};
      7: w = {5'b00100, 11'($urandom_range(0, 5) * 2)};
      8: w[15:11] = ($urandom_range(0, 1) == 0) ? 5'b00001 : 5'b11111;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mDmem[i] = 16'h0000;
    lastStAddr = '0; lastStData = '0; lastLdData = '0;

    // LBI R1,5; ADDI R2,R1,-1; HALT
    setVec(0, 3, 8, 16'h0004, 32'd3, 2, 1'b0);
    vecs[0].prog[0] = 16'hC105; vecs[0].prog[1] = 16'h415F;
    vecs[0].chkReg[0] = 3'd1; vecs[0].chkVal[0] = 16'h0005;
    vecs[0].chkReg[1] = 3'd2; vecs[0].chkVal[1] = 16'h0004;
    // LBI R3,0x10; LBI R4,0x7F; ST R4,[R3+2]; LD R5,[R3+2]; HALT
    setVec(1, 5, 9, 16'h0008, 32'd5, 3, 1'b1);
    vecs[1].prog[0] = 16'hC310; vecs[1].prog[1] = 16'hC47F;
    vecs[1].prog[2] = 16'h8382; vecs[1].prog[3] = 16'h8BA2;
    vecs[1].chkReg[0] = 3'd3; vecs[1].chkVal[0] = 16'h0010;
    vecs[1].chkReg[1] = 3'd4; vecs[1].chkVal[1] = 16'h007F;
    vecs[1].chkReg[2] = 3'd5; vecs[1].chkVal[2] = 16'h007F;
    // R1=0x00F0, R2=0x0F0F built by doubling, then the four ALU functions
    setVec(2, 17, 24, 16'h0020, 32'd17, 4, 1'b0);
    vecs[2].prog[0] = 16'hC178; vecs[2].prog[1] = 16'hD924; vecs[2].prog[2] = 16'hC20F;
    for (int i = 3; i <= 10; i++) vecs[2].prog[i] = 16'hDA48;
    vecs[2].prog[11] = 16'h424F; vecs[2].prog[12] = 16'hD94C; vecs[2].prog[13] = 16'hD951;
    vecs[2].prog[14] = 16'hD956; vecs[2].prog[15] = 16'hD95B;
    vecs[2].chkReg[0] = 3'd3; vecs[2].chkVal[0] = 16'h0FFF;
    vecs[2].chkReg[1] = 3'd4; vecs[2].chkVal[1] = 16'h0E1F;
    vecs[2].chkReg[2] = 3'd5; vecs[2].chkVal[2] = 16'h0FFF;
    vecs[2].chkReg[3] = 3'd6; vecs[2].chkVal[3] = 16'h00F0;
    // BEQZ R0,+4 (taken to 6); LBI R1,1; BEQZ R1,+4 (not taken); LBI R2,0x22; HALT
    setVec(3, 7, 10, 16'h000C, 32'd5, 3, 1'b0);
    vecs[3].prog[0] = 16'h6004; vecs[3].prog[1] = 16'hC755; vecs[3].prog[2] = 16'hC755;
    vecs[3].prog[3] = 16'hC101; vecs[3].prog[4] = 16'h6104; vecs[3].prog[5] = 16'hC222;
    vecs[3].chkReg[0] = 3'd7; vecs[3].chkVal[0] = 16'h0000;
    vecs[3].chkReg[1] = 3'd2; vecs[3].chkVal[1] = 16'h0022;
    vecs[3].chkReg[2] = 3'd1; vecs[3].chkVal[2] = 16'h0001;
    // J -2: spins at pc 0 while counting
    setVec(4, 1, 6, 16'h0000, 32'd6, 0, 1'b0);
    vecs[4].prog[0] = 16'h27FE;
    // unknown opcode 11111 then HALT, plus five frozen edges
    setVec(5, 2, 7, 16'h0002, 32'd2, 2, 1'b0);
    vecs[5].prog[0] = 16'hFFFF;
    vecs[5].chkReg[0] = 3'd7; vecs[5].chkVal[0] = 16'h0000;
    vecs[5].chkReg[1] = 3'd0; vecs[5].chkVal[1] = 16'h0000;

    #3;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_halt_count", {halt, cycle_count}, 33'h0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].nWords; i++) progBuf[i] = vecs[v].prog[i];
      loadProg(vecs[v].nWords);
      runEdges(vecs[v].edges);
      chk($sformatf("vec%0d_final_pc", v), pc, vecs[v].expPc);
      chk($sformatf("vec%0d_cycles", v), cycle_count, vecs[v].expCycles);
      for (int k = 0; k < vecs[v].nChk; k++)
        chk($sformatf("vec%0d_R%0d", v, vecs[v].chkReg[k]), sRegs[vecs[v].chkReg[k]], vecs[v].chkVal[k]);
      if (vecs[v].chkMem) begin
        chk("st_addr_data", {lastStAddr, lastStData}, {16'h0012, 16'h007F});
        chk("ld_data", lastLdData, 16'h007F);
      end
    end

    // Reset pulsed in the middle of a running program.
    progBuf[0] = 16'hC105; progBuf[1] = 16'h415F; progBuf[2] = 16'h27FE;
    loadProg(3);
    runEdges(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc_inst", {pc, inst}, 32'h0);
    chk("midrst_count", cycle_count, 32'h0);
    chk("midrst_ctl", {reg_write, write_reg, mem_read, mem_write, halt}, 7'h0);
    chk("midrst_data", {write_data, mem_addr}, 32'h0);
    chk("midrst_mem", {mem_data_in, mem_data_out}, 32'h0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_pc", pc, 16'h0000);
    chk("release_count", cycle_count, 32'h0);
    runEdges(5);

    // Randomized programs against the reference machine.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) progBuf[i] = randInst();
      loadProg(64);
      runEdges(150);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
